// File: rtl/lsd_pkg.sv
// Shared types and width helpers for the LSD segment filter slice.
package lsd_pkg;

  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int len_bitw(input int h_bitw, input int v_bitw);
    return 2 * ((h_bitw > v_bitw) ? h_bitw : v_bitw) + 1;
  endfunction

  localparam int DEF_FRAME_WIDTH  = 640;
  localparam int DEF_FRAME_HEIGHT = 480;
  localparam int DEF_H_BITW       = log2(DEF_FRAME_WIDTH);
  localparam int DEF_V_BITW       = log2(DEF_FRAME_HEIGHT);
  localparam int DEF_LEN_BITW     = len_bitw(DEF_H_BITW, DEF_V_BITW);

  typedef struct packed {
    logic [DEF_V_BITW-1:0] start_v;
    logic [DEF_H_BITW-1:0] start_h;
    logic [DEF_V_BITW-1:0] end_v;
    logic [DEF_H_BITW-1:0] end_h;
  } segment_t;

  typedef enum logic {
    FRAME_IDLE,
    FRAME_ACTIVE
  } frame_state_e;

endpackage

// File: rtl/lsd_segment_filter_if.sv
// Segment stream in, filtered segment stream and per-frame counts out.
interface lsd_segment_filter_if #(
  parameter int H_BITW   = 10,
  parameter int V_BITW   = 9,
  parameter int LEN_BITW = 21,
  parameter int CNT_BITW = 13
);
  logic                in_flag;
  logic                in_valid;
  logic [V_BITW-1:0]   in_start_v;
  logic [V_BITW-1:0]   in_end_v;
  logic [H_BITW-1:0]   in_start_h;
  logic [H_BITW-1:0]   in_end_h;
  logic [LEN_BITW-1:0] min_len_sq;

  logic                out_flag;
  logic                out_valid;
  logic [V_BITW-1:0]   out_start_v;
  logic [V_BITW-1:0]   out_end_v;
  logic [H_BITW-1:0]   out_start_h;
  logic [H_BITW-1:0]   out_end_h;
  logic [CNT_BITW-1:0] out_accept_cnt;
  logic [CNT_BITW-1:0] out_reject_cnt;
  logic                out_cnt_update;

  modport master (
    output in_flag, in_valid, in_start_v, in_end_v, in_start_h, in_end_h, min_len_sq,
    input  out_flag, out_valid, out_start_v, out_end_v, out_start_h, out_end_h,
           out_accept_cnt, out_reject_cnt, out_cnt_update
  );

  modport slave (
    input  in_flag, in_valid, in_start_v, in_end_v, in_start_h, in_end_h, min_len_sq,
    output out_flag, out_valid, out_start_v, out_end_v, out_start_h, out_end_h,
           out_accept_cnt, out_reject_cnt, out_cnt_update
  );
endinterface

// File: rtl/lsd_seg_len_sq.sv
// Two-stage |d| -> square pipe; len_sq is the combinational sum of the stage-2 squares.
// LSD_FILTER_HORIZ_REJECT_EN adds the dh > dv*ANGLE_RATIO test.
module lsd_seg_len_sq
  import lsd_pkg::*;
#(
  parameter int  H_BITW      = DEF_H_BITW,
  parameter int  V_BITW      = DEF_V_BITW,
  parameter int  LEN_BITW    = DEF_LEN_BITW,
  parameter type seg_t       = segment_t
`ifdef LSD_FILTER_HORIZ_REJECT_EN
  , parameter int ANGLE_RATIO = 4
`endif
) (
  input  logic                wclk,
  input  logic                n_rst,
  input  logic                in_flag,
  input  logic                in_valid,
  input  seg_t                in_seg,
  output logic                flg2,
  output logic                vld2,
  output seg_t                seg2,
  output logic [LEN_BITW-1:0] len_sq
`ifdef LSD_FILTER_HORIZ_REJECT_EN
  , output logic              horiz
`endif
);

  logic              vld1;
  logic              flg1;
  seg_t              seg1;
  logic [V_BITW-1:0] dv1;
  logic [H_BITW-1:0] dh1;

  logic [LEN_BITW-1:0] dv_sq;
  logic [LEN_BITW-1:0] dh_sq;

  always_ff @(posedge wclk) begin
    if (!n_rst) begin
      vld1 <= 1'b0;
      flg1 <= 1'b0;
      seg1 <= '0;
      dv1  <= '0;
      dh1  <= '0;
    end else begin
      vld1 <= in_flag & in_valid;
      flg1 <= in_flag;
      seg1 <= in_seg;
      dv1  <= (in_seg.end_v >= in_seg.start_v) ? in_seg.end_v - in_seg.start_v
                                                : in_seg.start_v - in_seg.end_v;
      dh1  <= (in_seg.end_h >= in_seg.start_h) ? in_seg.end_h - in_seg.start_h
                                                : in_seg.start_h - in_seg.end_h;
    end
  end

  always_ff @(posedge wclk) begin
    if (!n_rst) begin
      vld2  <= 1'b0;
      flg2  <= 1'b0;
      seg2  <= '0;
      dv_sq <= '0;
      dh_sq <= '0;
    end else begin
      vld2  <= vld1;
      flg2  <= flg1;
      seg2  <= seg1;
      dv_sq <= LEN_BITW'(dv1) * LEN_BITW'(dv1);
      dh_sq <= LEN_BITW'(dh1) * LEN_BITW'(dh1);
    end
  end

  // LEN_BITW leaves one bit of headroom over the wider square, so no carry is lost.
  assign len_sq = dv_sq + dh_sq;

`ifdef LSD_FILTER_HORIZ_REJECT_EN
  localparam int RATIO_BITW = V_BITW + log2(ANGLE_RATIO + 1);
  localparam int CMP_BITW   = (RATIO_BITW > H_BITW) ? RATIO_BITW : H_BITW;

  logic [CMP_BITW-1:0] dh_lin;
  logic [CMP_BITW-1:0] dv_ratio;

  always_ff @(posedge wclk) begin
    if (!n_rst) begin
      dh_lin   <= '0;
      dv_ratio <= '0;
    end else begin
      dh_lin   <= CMP_BITW'(dh1);
      dv_ratio <= CMP_BITW'(dv1) * CMP_BITW'(ANGLE_RATIO);
    end
  end

  assign horiz = dh_lin > dv_ratio;
`endif

endmodule

// File: rtl/lsd_segment_filter.sv
// Length/cap filter with 3-cycle latency and per-frame accept/reject counts.
// Optional macro: LSD_FILTER_HORIZ_REJECT_EN (reject near-horizontal segments).
module lsd_segment_filter
  import lsd_pkg::*;
#(
  parameter int FRAME_HEIGHT = -1,
  parameter int FRAME_WIDTH  = -1,
  parameter int MAX_LINES    = 4096,
  parameter int ANGLE_RATIO  = 4
) (
  input logic                 wclk,
  input logic                 n_rst,
  lsd_segment_filter_if.slave lsd
);

  localparam int FH       = (FRAME_HEIGHT > 0) ? FRAME_HEIGHT : DEF_FRAME_HEIGHT;
  localparam int FW       = (FRAME_WIDTH  > 0) ? FRAME_WIDTH  : DEF_FRAME_WIDTH;
  localparam int V_BITW   = log2(FH);
  localparam int H_BITW   = log2(FW);
  localparam int LEN_BITW = len_bitw(H_BITW, V_BITW);
  localparam int CNT_BITW = log2(MAX_LINES) + 1;

  typedef struct packed {
    logic [V_BITW-1:0] start_v;
    logic [H_BITW-1:0] start_h;
    logic [V_BITW-1:0] end_v;
    logic [H_BITW-1:0] end_h;
  } seg_t;

  seg_t                seg_in;
  seg_t                seg2;
  seg_t                seg_q;
  logic                flg2;
  logic                vld2;
  logic [LEN_BITW-1:0] len_sq;
  logic                pass;
  logic                frame_end;
  logic                horiz_rej;

  logic                valid_q;
  logic                cnt_update_q;
  logic [CNT_BITW-1:0] acc_cnt;
  logic [CNT_BITW-1:0] rej_cnt;
  logic [CNT_BITW-1:0] acc_lat;
  logic [CNT_BITW-1:0] rej_lat;

  frame_state_e state_q;
  frame_state_e state_d;

  assign seg_in = '{start_v: lsd.in_start_v, start_h: lsd.in_start_h,
                    end_v:   lsd.in_end_v,   end_h:   lsd.in_end_h};

  lsd_seg_len_sq #(
    .H_BITW      (H_BITW),
    .V_BITW      (V_BITW),
    .LEN_BITW    (LEN_BITW),
    .seg_t       (seg_t)
`ifdef LSD_FILTER_HORIZ_REJECT_EN
    , .ANGLE_RATIO (ANGLE_RATIO)
`endif
  ) u_len_sq (
    .wclk     (wclk),
    .n_rst    (n_rst),
    .in_flag  (lsd.in_flag),
    .in_valid (lsd.in_valid),
    .in_seg   (seg_in),
    .flg2     (flg2),
    .vld2     (vld2),
    .seg2     (seg2),
    .len_sq   (len_sq)
`ifdef LSD_FILTER_HORIZ_REJECT_EN
    , .horiz  (horiz_rej)
`endif
  );

`ifndef LSD_FILTER_HORIZ_REJECT_EN
  assign horiz_rej = 1'b0;
`endif

  assign pass = vld2 & (len_sq >= lsd.min_len_sq) & ~horiz_rej
              & (acc_cnt < CNT_BITW'(MAX_LINES));

  // The frame state register doubles as the stage-3 flag.
  always_ff @(posedge wclk) begin
    if (!n_rst) state_q <= FRAME_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flg2) state_d = FRAME_ACTIVE;
    else      state_d = FRAME_IDLE;
  end

  always_comb begin
    frame_end    = (state_q == FRAME_ACTIVE) && !flg2;
    lsd.out_flag = (state_q == FRAME_ACTIVE);
  end

  // Counters clear whenever no flagged slot reaches stage 3; the latch on the
  // falling edge therefore still sees the last flagged cycle's increment.
  always_ff @(posedge wclk) begin
    if (!n_rst) begin
      valid_q      <= 1'b0;
      cnt_update_q <= 1'b0;
      seg_q        <= '0;
      acc_cnt      <= '0;
      rej_cnt      <= '0;
      acc_lat      <= '0;
      rej_lat      <= '0;
    end else begin
      valid_q      <= pass;
      cnt_update_q <= frame_end;
      seg_q        <= seg2;
      if (frame_end) begin
        acc_lat <= acc_cnt;
        rej_lat <= rej_cnt;
      end
      if (!flg2) begin
        acc_cnt <= '0;
        rej_cnt <= '0;
      end else if (vld2) begin
        if (pass)              acc_cnt <= acc_cnt + CNT_BITW'(1);
        else if (rej_cnt != '1) rej_cnt <= rej_cnt + CNT_BITW'(1);
      end
    end
  end

  assign lsd.out_valid      = valid_q;
  assign lsd.out_start_v    = seg_q.start_v;
  assign lsd.out_start_h    = seg_q.start_h;
  assign lsd.out_end_v      = seg_q.end_v;
  assign lsd.out_end_h      = seg_q.end_h;
  assign lsd.out_accept_cnt = acc_lat;
  assign lsd.out_reject_cnt = rej_lat;
  assign lsd.out_cnt_update = cnt_update_q;

endmodule

// File: tb/tb_lsd_segment_filter.sv
// Scoreboard bench for lsd_segment_filter: 640x480, MAX_LINES=8, per-frame reference model.
// Honours LSD_FILTER_HORIZ_REJECT_EN in its model when the macro is defined.
module tb_lsd_segment_filter;
  import lsd_pkg::*;

  localparam int H        = 10;
  localparam int V        = 9;
  localparam int LEN      = 21;
  localparam int CNT      = 4;
  localparam int MAXL     = 8;
  localparam int REJ_SAT  = 15;

  typedef struct {
    int acc;
    int rej;
  } cnt_t;

  logic wclk = 1'b0;
  logic n_rst = 1'b0;
  always #5 wclk = ~wclk;

  lsd_segment_filter_if #(.H_BITW(H), .V_BITW(V), .LEN_BITW(LEN), .CNT_BITW(CNT)) bus ();

  lsd_segment_filter #(
    .FRAME_HEIGHT (480),
    .FRAME_WIDTH  (640),
    .MAX_LINES    (MAXL),
    .ANGLE_RATIO  (4)
  ) dut (
    .wclk  (wclk),
    .n_rst (n_rst),
    .lsd   (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;
  bit mon_en   = 0;

  segment_t exp_seg_q[$];
  cnt_t     exp_cnt_q[$];
  int       m_acc = 0;
  int       m_rej = 0;
  bit       m_prev_flag = 0;
  int       cur_min = 0;
  logic [2:0] fh = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Expected out_flag: input flag three accepted clock edges ago.
  always @(posedge wclk) begin
    if (!n_rst) fh <= '0;
    else        fh <= {fh[1:0], bus.in_flag};
  end

  segment_t mon_seg;
  cnt_t     mon_cnt;
  always @(negedge wclk) begin
    if (mon_en) begin
      chk("out_flag", bus.out_flag, fh[2]);
      if (bus.out_valid !== 1'b0) begin
        if (exp_seg_q.size() == 0) begin
          chk("out_valid_unexpected", bus.out_valid, 0);
        end else begin
          mon_seg = exp_seg_q.pop_front();
          chk("out_start_v", bus.out_start_v, mon_seg.start_v);
          chk("out_start_h", bus.out_start_h, mon_seg.start_h);
          chk("out_end_v",   bus.out_end_v,   mon_seg.end_v);
          chk("out_end_h",   bus.out_end_h,   mon_seg.end_h);
        end
      end
      if (bus.out_cnt_update !== 1'b0) begin
        if (exp_cnt_q.size() == 0) begin
          chk("cnt_update_unexpected", bus.out_cnt_update, 0);
        end else begin
          mon_cnt = exp_cnt_q.pop_front();
          chk("out_accept_cnt", bus.out_accept_cnt, mon_cnt.acc);
          chk("out_reject_cnt", bus.out_reject_cnt, mon_cnt.rej);
        end
      end
    end
  end

  task automatic set_min(input int v);
    cur_min = v;
    bus.min_len_sq = LEN'(v);
  endtask

  // Applies one input cycle and updates the frame-level reference model.
  task automatic drive(input bit flag, input bit valid, input int sv, input int sh,
                       input int ev, input int eh);
    int dv, dh, len;
    bit ok;
    segment_t s;
    bus.in_flag    = flag;
    bus.in_valid   = valid;
    bus.in_start_v = V'(sv);
    bus.in_start_h = H'(sh);
    bus.in_end_v   = V'(ev);
    bus.in_end_h   = H'(eh);
    if (flag && valid) begin
      dv  = iabs(ev - sv);
      dh  = iabs(eh - sh);
      len = dv * dv + dh * dh;
      ok  = (len >= cur_min);
`ifdef LSD_FILTER_HORIZ_REJECT_EN
      if (dh > dv * 4) ok = 0;
`endif
      if (ok && m_acc < MAXL) begin
        s.start_v = V'(sv);
        s.start_h = H'(sh);
        s.end_v   = V'(ev);
        s.end_h   = H'(eh);
        exp_seg_q.push_back(s);
        m_acc++;
      end else if (m_rej < REJ_SAT) begin
        m_rej++;
      end
    end
    if (m_prev_flag && !flag) begin
      exp_cnt_q.push_back('{acc: m_acc, rej: m_rej});
      m_acc = 0;
      m_rej = 0;
    end
    m_prev_flag = flag;
    @(negedge wclk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_seg(input bit flag);
    int sv, sh, ev, eh;
    sv = $urandom_range(0, 479);
    sh = $urandom_range(0, 639);
    if ($urandom_range(0, 1) == 1) begin
      ev = $urandom_range(0, 479);
      eh = $urandom_range(0, 639);
    end else begin
      ev = sv + $urandom_range(0, 10);
      eh = sh + $urandom_range(0, 10);
      if (ev > 479) ev = 479;
      if (eh > 639) eh = 639;
    end
    drive(flag, ($urandom_range(0, 9) < 7), sv, sh, ev, eh);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    bus.in_flag  = 1'b0;
    bus.in_valid = 1'b0;
    m_acc = 0;
    m_rej = 0;
    m_prev_flag = 0;
    @(negedge wclk);
    n_rst = 1'b1;
    chk("rst_out_valid",  bus.out_valid, 0);
    chk("rst_out_flag",   bus.out_flag, 0);
    chk("rst_accept_cnt", bus.out_accept_cnt, 0);
    chk("rst_reject_cnt", bus.out_reject_cnt, 0);
    chk("rst_cnt_update", bus.out_cnt_update, 0);
  endtask

  initial begin
    bus.in_flag = 0; bus.in_valid = 0;
    bus.in_start_v = '0; bus.in_start_h = '0; bus.in_end_v = '0; bus.in_end_h = '0;
    set_min(100);
    @(negedge wclk);
    mon_en = 1;
    @(negedge wclk);
    do_reset();
    idle(4);

    // Exactly at threshold, then below it.
    drive(1, 1, 10, 10, 10, 20);
    idle(6);
    drive(1, 1, 10, 10, 13, 14);
    idle(6);

    // Cap: 12 long segments in one frame.
    for (int i = 0; i < 12; i++) drive(1, 1, i * 20, 0, i * 20 + 15, 300 + i);
    idle(6);

    // Unflagged valid is ignored; a 1-cycle empty frame still reports 0/0.
    drive(0, 1, 0, 0, 400, 600);
    drive(1, 0, 0, 0, 0, 0);
    idle(6);

    // Back-to-back frames separated by one idle cycle.
    for (int i = 0; i < 3; i++) drive(1, 1, 5, 5, 100 + i, 200);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) drive(1, 1, 7, 7, 7, 90 + i);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    idle(6);

    // Reject counter saturation.
    for (int i = 0; i < 20; i++) drive(1, 1, 1, 1, 2, 2);
    idle(6);

    // Zero threshold accepts a zero-length segment.
    set_min(0);
    drive(1, 1, 5, 5, 5, 5);
    idle(6);

`ifdef LSD_FILTER_HORIZ_REJECT_EN
    set_min(100);
    drive(1, 1, 100, 0, 101, 50);
    drive(1, 1, 0, 0, 40, 5);
    idle(6);
`endif

    // Reset mid-frame with segments in flight.
    set_min(100);
    idle(4);
    for (int i = 0; i < 3; i++) drive(1, 1, 2, 2, 3, 3 + i);
    do_reset();
    idle(6);

    // Randomised frames.
    for (int f = 0; f < 30; f++) begin
      int len;
      len = $urandom_range(1, 16);
      for (int c = 0; c < len; c++) rand_seg(1);
      if ($urandom_range(0, 2) == 0) begin
        drive(0, $urandom_range(0, 1), 30, 30, 300, 500);
      end else begin
        idle(4);
        set_min($urandom_range(0, 3000));
      end
    end
    idle(10);

    chk("seg_queue_drained", exp_seg_q.size(), 0);
    chk("cnt_queue_drained", exp_cnt_q.size(), 0);
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
